// File: rtl/tt_pkg.sv
// Shared definitions for the tt_sweep truth-table sweeper: state encoding,
// row-count helper and the supported parameter ranges.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  localparam int N_MIN = 1;
  localparam int N_MAX = 8;
  localparam int M_MIN = 1;
  localparam int M_MAX = 16;

  function automatic int ROWS(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_lut_sel.sv
// Purely combinational single-bit lookup: picks bit `sel` out of a 2^N-bit
// minterm mask.
module tt_lut_sel #(
  parameter int N = 3
) (
  input  logic [(1<<N)-1:0] mask,
  input  logic [N-1:0]      sel,
  output logic              value
);

  assign value = mask[sel];

endmodule

// File: rtl/tt_sweep.sv
// Truth-table sweeper: latches M N-input function masks on start and streams
// every row over valid/ready. Optional row checking under TT_SWEEP_CHECK_EN.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int N = 3,
  parameter int M = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [M*ROWS(N)-1:0] func_mask,
`ifdef TT_SWEEP_CHECK_EN
  input  logic [M*ROWS(N)-1:0] exp_mask,
  output logic [N:0]           err_count,
`endif
  output logic                 busy,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [N-1:0]         row_in,
  output logic [M-1:0]         row_out,
  output logic                 done
);

  localparam int R = ROWS(N);

  tt_state_e          state_q, state_d;
  logic [N-1:0]       idx_q;
  logic [M*R-1:0]     mask_q;
  logic [M-1:0]       row_bits;
  logic               run, xfer, last, accept;

  assign run    = (state_q == RUN);
  assign xfer   = run && row_ready;
  assign last   = (idx_q == '1);
  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        // abort wins over the final-row transition, so no done pulse
        if (abort)             state_d = IDLE;
        else if (xfer && last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mask_q <= func_mask;
        idx_q  <= '0;
      end else if (xfer && !last) begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_fn
    tt_lut_sel #(.N(N)) u_sel (
      .mask  (mask_q[k*R +: R]),
      .sel   (idx_q),
      .value (row_bits[k])
    );
  end

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign row_valid = run;
  assign row_in    = run ? idx_q : '0;
  assign row_out   = run ? row_bits : '0;
  assign done      = (state_q == DONE);

`ifdef TT_SWEEP_CHECK_EN
  logic [M*R-1:0] exp_q;
  logic [M-1:0]   exp_bits;

  for (genvar k = 0; k < M; k++) begin : g_exp
    tt_lut_sel #(.N(N)) u_sel (
      .mask  (exp_q[k*R +: R]),
      .sel   (idx_q),
      .value (exp_bits[k])
    );
  end

  // a row transferred in the abort cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= '0;
      err_count <= '0;
    end else if (accept) begin
      exp_q     <= exp_mask;
      err_count <= '0;
    end else if (xfer && (row_bits != exp_bits)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep.sv
// Directed self-checking bench for tt_sweep (N=3, M=2); the err_count checks
// are built only when TT_SWEEP_CHECK_EN is defined.
module tb_tt_sweep;

  localparam int N = 3;
  localparam int M = 2;
  localparam logic [15:0] FM = {8'b1000_0000, 8'b0000_0100};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  func_mask = FM;
  logic [15:0]  exp_mask = FM;
  logic         busy, row_valid, done;
  logic         row_ready = 1'b1;
  logic [N-1:0] row_in;
  logic [M-1:0] row_out;
  logic [N:0]   err_count;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_tab [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};

  always #5 clk = ~clk;

  tt_sweep #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .func_mask (func_mask),
`ifdef TT_SWEEP_CHECK_EN
    .exp_mask  (exp_mask),
    .err_count (err_count),
`endif
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_in    (row_in),
    .row_out   (row_out),
    .done      (done)
  );

`ifndef TT_SWEEP_CHECK_EN
  assign err_count = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep with optional stall (stall_n cycles at row stall_at) or abort at abort_at.
  task automatic sweep(input int stall_at, input int stall_n, input int abort_at);
    int row = 0;
    int stalls = 0;
    int cyc = 0;
    bit fin = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    func_mask = ~FM;
    cyc = 1;
    while (!fin && cyc < 64) begin
      if (row < 8) begin
        chk("row_valid", 32'(row_valid), 1);
        chk("row_in", 32'(row_in), row);
        chk("row_out", 32'(row_out), 32'(exp_tab[row]));
        chk("done_early", 32'(done), 0);
        row_ready = !(row == stall_at && stalls < stall_n);
        abort = (row == abort_at);
        step();
        cyc++;
        if (abort) begin
          abort = 1'b0;
          chk("abort_busy", 32'(busy), 0);
          chk("abort_valid", 32'(row_valid), 0);
          chk("abort_done", 32'(done), 0);
          step();
          chk("abort_done2", 32'(done), 0);
          fin = 1;
        end else if (row_ready) begin
          row++;
        end else begin
          stalls++;
        end
      end else begin
        chk("done", 32'(done), 1);
        chk("done_cycle", cyc, 9 + stall_n);
        chk("done_valid", 32'(row_valid), 0);
        chk("done_busy", 32'(busy), 1);
        step();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        fin = 1;
      end
    end
    if (!fin) chk("sweep_timeout", 0, 1);
    row_ready = 1'b1;
    func_mask = FM;
  endtask

  initial begin
    int dones;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(row_valid), 0);
    chk("rst_row_in", 32'(row_in), 0);
    chk("rst_row_out", 32'(row_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_count), 0);
    step();
    rst_n = 1'b1;
    step();

    // plain sweep, then stall at row 4
    sweep(-1, 0, -1);
    sweep(4, 3, -1);

    // abort at row 5, then a fresh sweep from row 0
    sweep(-1, 0, 5);
    sweep(-1, 0, -1);

    // asynchronous reset at row 3
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_row", 32'(row_in), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(row_valid), 0);
    chk("arst_row_in", 32'(row_in), 0);
    chk("arst_done", 32'(done), 0);
    start = 1'b1;
    repeat (2) step();
    chk("rst_start_busy", 32'(busy), 0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    sweep(-1, 0, -1);

    // start held high: exactly one done per sweep, restart after IDLE
    dones = 0;
    start = 1'b1;
    step();
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8) chk("held_row", 32'(row_in), c - 1);
      if (done) dones++;
      if (c == 10) chk("held_idle", 32'(busy), 0);
      step();
    end
    chk("held_dones", dones, 1);
    chk("held_restart_valid", 32'(row_valid), 1);
    chk("held_restart_row", 32'(row_in), 0);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("held_abort_busy", 32'(busy), 0);

`ifdef TT_SWEEP_CHECK_EN
    exp_mask = FM ^ 16'h0042;
    sweep(-1, 0, -1);
    chk("err_count", 32'(err_count), 2);
    exp_mask = FM;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_clear", 32'(err_count), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
